agg_sram_writer: RTL and testbench
==================================

# agg_sram_writer

Write-side aggregation stage directly upstream of the SRAM bank wrapper. Accepts a stream of 16-bit words over a valid/ready handshake and packs them into 4-word lines in a double-buffered aggregation register. Issues each full line as a single wide write (address, active-high chip enable, active-high write enable, 4×16-bit data) to the bank wrapper, which performs the SRAM polarity inversion and flattening. Sequential addressing wraps, and a flush input closes a partial line.

## Interface
- DATA_WIDTH, 16, word width
- FETCH_WIDTH, 4, words per SRAM line
- ADDR_WIDTH, 8, SRAM line address width (depth 256)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clk_en  input  1  global stall; 0 freezes all state
- start_addr  input  ADDR_WIDTH  first line address; sampled only on clear
- clear  input  1  synchronous soft reset: empties buffers, loads write pointer from start_addr
- data_in  input  DATA_WIDTH  input word
- data_in_valid  input  1  word offered
- data_in_ready  output  1  word accepted when valid&ready&clk_en
- flush  input  1  close the current partial line (unfilled words = 0)
- mem_wr_grant  input  1  bank accepts the write offered this cycle
- mem_addr_in_bank  output  ADDR_WIDTH  write line address
- mem_cen_in_bank  output  1  active-high chip enable
- mem_wen_in_bank  output  1  active-high write enable (always equal to mem_cen_in_bank)
- mem_data_in_bank  output  FETCH_WIDTH×DATA_WIDTH  line data; element i = word i of line
- lines_written  output  16  saturating count of completed writes
- busy  output  1  any word buffered or any line pending

## Operation
- Two aggregation buffers (buf 0/1), each FETCH_WIDTH words plus a pending flag. Fill pointer fsel, word index widx (0..3), drain pointer dsel.
- Accepted word goes to buf[fsel][widx]; widx increments. On widx==3 accept, or flush with widx>0 (after the same-cycle word, if any): buf[fsel] is marked pending, widx→0, fsel toggles. Words of a flushed line beyond widx are zero-filled (buffer zeroed when it is released).
- flush with widx==0 and no same-cycle word: no effect.
- data_in_ready = clk_en & ~pending[fsel] & ~clear.
- Write FSM, two states: IDLE (pending[dsel]==0; cen=wen=0) and WRITE (pending[dsel]==1; cen=wen=clk_en, addr=wr_ptr, data=buf[dsel]). When a write is offered and mem_wr_grant==1: pending[dsel] clears, buffer zeroed, dsel toggles, wr_ptr+1 (wraps 255→0), lines_written+1 (saturates at 0xFFFF). Next state is WRITE if the other buffer is pending, else IDLE.
- Lines are written strictly in fill order; one line per granted cycle, back-to-back writes allowed.
- mem_data_in_bank is held stable while the write is offered and not granted.
- clear: all pending/widx/fsel/dsel zeroed, wr_ptr=start_addr, lines_written=0; overrides simultaneous accept/flush/grant.
- clk_en=0: no state change, ready=0, cen=wen=0.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr=0, lines_written=0, all buffers zero, pending=0, fsel=dsel=0, widx=0. Outputs: data_in_ready=1 once out of reset (with clk_en=1), cen=wen=0, addr=0, data=0, busy=0.
- Latency: 4th word accepted at edge k → cen=1 during cycle k+1 (registered pending; no combinational valid→cen path).
- mem outputs are decoded from registers only; mem_wr_grant feeds only next-state logic.
- Throughput: with grant held high, one word per cycle is sustained indefinitely (the second buffer absorbs the next line while the first drains).
- Both buffers pending: ready=0 until the grant edge; ready rises in the following cycle.
- Reset asserted mid-line or mid-write: all content discarded immediately; no write is offered after deassertion.

## Structure
- Shared package agg_sram_pkg: DATA_WIDTH/FETCH_WIDTH/ADDR_WIDTH defaults, line_t typedef (logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0]), write-FSM state enum {IDLE, WRITE}.
- One sub-module, agg_line_buffer: a single FETCH_WIDTH-word buffer with word write, pending flag, release/zero. Instantiated twice; the top holds fsel/dsel/widx, the FSM, and the address counter.

## Test plan
- Reset, start_addr=0x10 with clear, push 0x0001..0x0004 with grant=1 → one write: addr 0x10, data {4,3,2,1} (element0=1), cen=wen=1 for exactly one cycle, lines_written=1.
- Push 12 consecutive words with grant tied 0 for 10 cycles → ready drops after word 8; after grant=1, lines at 0x00, 0x01, 0x02 in order, no word lost.
- Push 0xAAAA, 0xBBBB, then flush with a third word 0xCCCC in the same cycle → line {0,CCCC,BBBB,AAAA}; a lone flush with empty buffer → no write.
- start_addr=0xFE, write 3 lines → addresses 0xFE, 0xFF, 0x00.
- clk_en=0 for 5 cycles mid-line and during an offered write → no accepts, cen=0, outputs unchanged; resumes exactly where it stopped.
- Assert rst_n low asynchronously (between clock edges) with 2 words buffered and one line pending → cen=0, busy=0 immediately; after release, 4 new words yield one write at addr 0x00.

Source files
------------

// File: rtl/agg_sram_pkg.sv
// agg_sram_pkg: shared widths, line type and write-FSM state for the SRAM write aggregator
package agg_sram_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FETCH_WIDTH = 4;
  localparam int ADDR_WIDTH = 8;
  typedef logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] line_t;
  typedef enum logic {IDLE, WRITE} wr_state_t;
endpackage

// File: rtl/agg_line_buffer.sv
// agg_line_buffer: one FETCH_WIDTH-word line with word write, pending flag and release-to-zero
module agg_line_buffer import agg_sram_pkg::*; #(
  parameter int DATA_WIDTH = agg_sram_pkg::DATA_WIDTH,
  parameter int FETCH_WIDTH = agg_sram_pkg::FETCH_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic clear,
  input  logic wr_en,
  input  logic [$clog2(FETCH_WIDTH)-1:0] widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic close,
  input  logic rel,
  output logic pending,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] line
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line <= '0;
      pending <= 1'b0;
    end else if (clk_en) begin
      if (clear || rel) begin
        line <= '0;
        pending <= 1'b0;
      end else begin
        if (wr_en) line[widx] <= wdata;
        if (close) pending <= 1'b1;
      end
    end
endmodule

// File: rtl/agg_sram_writer.sv
// agg_sram_writer: packs a 16-bit word stream into double-buffered 4-word lines and writes them to the SRAM bank
module agg_sram_writer import agg_sram_pkg::*; #(
  parameter int DATA_WIDTH = agg_sram_pkg::DATA_WIDTH,
  parameter int FETCH_WIDTH = agg_sram_pkg::FETCH_WIDTH,
  parameter int ADDR_WIDTH = agg_sram_pkg::ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic data_in_valid,
  output logic data_in_ready,
  input  logic flush,
  input  logic mem_wr_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr_in_bank,
  output logic mem_cen_in_bank,
  output logic mem_wen_in_bank,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_in_bank,
  output logic [15:0] lines_written,
  output logic busy
);
  localparam int IW = $clog2(FETCH_WIDTH);
  wr_state_t state, state_nxt;
  logic [IW-1:0] widx;
  logic fsel, dsel, accept, last, close, fire;
  logic [1:0] pend;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] bufs [2];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  assign data_in_ready = clk_en & ~pend[fsel] & ~clear;
  assign accept = data_in_valid & data_in_ready;
  assign last = widx == IW'(FETCH_WIDTH - 1);
  assign close = clk_en & ~clear & ((accept & last) | (flush & (accept | (widx != '0))));
  assign fire = mem_cen_in_bank & mem_wr_grant & ~clear;
  assign busy = (widx != '0) | (|pend);
  for (genvar b = 0; b < 2; b++) begin : g_buf
    agg_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .FETCH_WIDTH(FETCH_WIDTH)) u_buf (
      .clk(clk),
      .rst_n(rst_n),
      .clk_en(clk_en),
      .clear(clear),
      .wr_en(accept & (fsel == 1'(b))),
      .widx(widx),
      .wdata(data_in),
      .close(close & (fsel == 1'(b))),
      .rel(fire & (dsel == 1'(b))),
      .pending(pend[b]),
      .line(bufs[b])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      widx <= '0;
      fsel <= 1'b0;
      dsel <= 1'b0;
      wr_ptr <= '0;
      lines_written <= '0;
    end else if (clk_en) begin
      if (clear) begin
        widx <= '0;
        fsel <= 1'b0;
        dsel <= 1'b0;
        wr_ptr <= start_addr;
        lines_written <= '0;
      end else begin
        widx <= close ? '0 : accept ? widx + 1'b1 : widx;
        fsel <= fsel ^ close;
        dsel <= dsel ^ fire;
        wr_ptr <= wr_ptr + ADDR_WIDTH'(fire);
        lines_written <= lines_written + 16'(fire & ~&lines_written);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = !clk_en ? state :
                clear ? IDLE :
                fire ? ((pend[~dsel] | (close & (fsel != dsel))) ? WRITE : IDLE) :
                (close & (state == IDLE)) ? WRITE : state;
  end
  always_comb begin
    mem_cen_in_bank = clk_en & (state == WRITE);
    mem_wen_in_bank = mem_cen_in_bank;
    mem_addr_in_bank = wr_ptr;
    mem_data_in_bank = bufs[dsel];
  end
endmodule

// File: tb/tb_agg_sram_writer.sv
// tb_agg_sram_writer: queue-based reference model plus directed and random stimulus for agg_sram_writer
module tb_agg_sram_writer;
  logic clk = 0, rst_n = 0, clk_en = 1, clear = 0, data_in_valid = 0, flush = 0, mem_wr_grant = 0;
  logic [7:0] start_addr = 0;
  logic [15:0] data_in = 0;
  logic data_in_ready, mem_cen_in_bank, mem_wen_in_bank, busy;
  logic [7:0] mem_addr_in_bank;
  logic [3:0][15:0] mem_data_in_bank;
  logic [15:0] lines_written;
  int checks = 0, fails = 0, cen_cycles = 0;
  logic [15:0] cur[$];
  logic [63:0] pq[$];
  logic [71:0] wlog[$];
  logic [7:0] mptr;
  int mlw;
  bit acc;
  always #5 clk = ~clk;
  agg_sram_writer dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start_addr(start_addr), .clear(clear),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .flush(flush), .mem_wr_grant(mem_wr_grant), .mem_addr_in_bank(mem_addr_in_bank),
    .mem_cen_in_bank(mem_cen_in_bank), .mem_wen_in_bank(mem_wen_in_bank),
    .mem_data_in_bank(mem_data_in_bank), .lines_written(lines_written), .busy(busy)
  );
  function automatic void chk(string n, logic [71:0] a, logic [71:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction
  function automatic void model_reset();
    cur.delete();
    pq.delete();
    mptr = 0;
    mlw = 0;
  endfunction
  function automatic void model_step();
    bit rdy = clk_en && !clear && pq.size() < 2;
    bit cen = clk_en && pq.size() > 0;
    logic [63:0] l;
    acc = 0;
    if (!rst_n || !clk_en) return;
    if (clear) begin
      model_reset();
      mptr = start_addr;
      return;
    end
    if (cen && mem_wr_grant) begin
      void'(pq.pop_front());
      mptr++;
      if (mlw < 65535) mlw++;
    end
    if (data_in_valid && rdy) begin
      cur.push_back(data_in);
      acc = 1;
    end
    if (cur.size() == 4 || (flush && cur.size() > 0)) begin
      l = '0;
      for (int i = 0; i < cur.size(); i++) l[16*i +: 16] = cur[i];
      pq.push_back(l);
      cur.delete();
    end
  endfunction
  always @(negedge clk) begin : cmp
    bit ecen;
    ecen = clk_en && pq.size() > 0;
    chk("ready", 72'(data_in_ready), 72'(clk_en && !clear && pq.size() < 2));
    chk("cen", 72'(mem_cen_in_bank), 72'(ecen));
    chk("wen", 72'(mem_wen_in_bank), 72'(ecen));
    chk("busy", 72'(busy), 72'(cur.size() > 0 || pq.size() > 0));
    chk("lines_written", 72'(lines_written), 72'(mlw));
    if (ecen) begin
      chk("addr", 72'(mem_addr_in_bank), 72'(mptr));
      chk("data", 72'(mem_data_in_bank), 72'(pq[0]));
    end
    if (mem_cen_in_bank) cen_cycles++;
    if (mem_cen_in_bank && mem_wr_grant) wlog.push_back({mem_addr_in_bank, mem_data_in_bank});
  end
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) tick();
  endtask
  task automatic do_clear(logic [7:0] a);
    start_addr = a;
    clear = 1;
    tick();
    clear = 0;
  endtask
  task automatic push(logic [15:0] w);
    bit ok = 0;
    data_in = w;
    data_in_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = acc;
    end
    data_in_valid = 0;
    if (!ok) chk("push_timeout", 72'(0), 72'(1));
  endtask
  function automatic logic [71:0] wl(int i);
    return i < wlog.size() ? wlog[i] : '1;
  endfunction
  initial begin
    logic [63:0] snap;
    model_reset();
    #12 rst_n = 1;
    chk("rst_ready", 72'(data_in_ready), 72'(1));
    chk("rst_cen", 72'(mem_cen_in_bank), 72'(0));
    chk("rst_addr", 72'(mem_addr_in_bank), 72'(0));
    chk("rst_data", 72'(mem_data_in_bank), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_lines", 72'(lines_written), 72'(0));
    mem_wr_grant = 1;
    do_clear(8'h10);
    wlog.delete();
    cen_cycles = 0;
    for (int i = 1; i <= 4; i++) push(16'(i));
    idle(3);
    chk("t1_nwrites", 72'(wlog.size()), 72'(1));
    chk("t1_line", wl(0), {8'h10, 64'h0004_0003_0002_0001});
    chk("t1_cen_cycles", 72'(cen_cycles), 72'(1));
    chk("t1_lines", 72'(lines_written), 72'(1));
    mem_wr_grant = 0;
    do_clear(8'h00);
    wlog.delete();
    for (int i = 1; i <= 8; i++) push(16'h0100 + 16'(i));
    chk("t2_ready_low", 72'(data_in_ready), 72'(0));
    data_in = 16'h0109;
    data_in_valid = 1;
    idle(2);
    chk("t2_held", 72'(acc), 72'(0));
    mem_wr_grant = 1;
    for (int i = 9; i <= 12; i++) push(16'h0100 + 16'(i));
    idle(6);
    chk("t2_nwrites", 72'(wlog.size()), 72'(3));
    chk("t2_line0", wl(0), {8'h00, 64'h0104_0103_0102_0101});
    chk("t2_line1", wl(1), {8'h01, 64'h0108_0107_0106_0105});
    chk("t2_line2", wl(2), {8'h02, 64'h010C_010B_010A_0109});
    wlog.delete();
    push(16'hAAAA);
    push(16'hBBBB);
    data_in = 16'hCCCC;
    data_in_valid = 1;
    flush = 1;
    tick();
    data_in_valid = 0;
    flush = 0;
    idle(3);
    chk("t3_flush_line", wl(0), {8'h03, 64'h0000_CCCC_BBBB_AAAA});
    flush = 1;
    tick();
    flush = 0;
    idle(3);
    chk("t3_lone_flush", 72'(wlog.size()), 72'(1));
    do_clear(8'hFE);
    wlog.delete();
    for (int i = 0; i < 12; i++) push(16'(i));
    idle(4);
    chk("t4_addr0", 72'(wl(0) >> 64), 72'(8'hFE));
    chk("t4_addr1", 72'(wl(1) >> 64), 72'(8'hFF));
    chk("t4_addr2", 72'(wl(2) >> 64), 72'(8'h00));
    mem_wr_grant = 0;
    do_clear(8'h00);
    wlog.delete();
    for (int i = 0; i < 6; i++) push(16'h0200 + 16'(i));
    snap = mem_data_in_bank;
    clk_en = 0;
    data_in_valid = 1;
    mem_wr_grant = 1;
    idle(5);
    chk("t5_stall_data", 72'(mem_data_in_bank), 72'(snap));
    chk("t5_stall_cen", 72'(mem_cen_in_bank), 72'(0));
    chk("t5_stall_writes", 72'(wlog.size()), 72'(0));
    data_in_valid = 0;
    clk_en = 1;
    push(16'h0206);
    push(16'h0207);
    idle(4);
    chk("t5_line0", wl(0), {8'h00, 64'h0203_0202_0201_0200});
    chk("t5_line1", wl(1), {8'h01, 64'h0207_0206_0205_0204});
    mem_wr_grant = 0;
    do_clear(8'h00);
    wlog.delete();
    for (int i = 0; i < 6; i++) push(16'h0300 + 16'(i));
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_cen", 72'(mem_cen_in_bank), 72'(0));
    chk("t6_rst_busy", 72'(busy), 72'(0));
    tick();
    #2 rst_n = 1;
    mem_wr_grant = 1;
    idle(3);
    chk("t6_no_write", 72'(wlog.size()), 72'(0));
    for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i));
    idle(3);
    chk("t6_line", wl(0), {8'h00, 64'h0403_0402_0401_0400});
    for (int i = 0; i < 3000; i++) begin
      clk_en = ($urandom % 8) != 0;
      data_in_valid = ($urandom % 4) != 0;
      data_in = 16'($urandom);
      flush = ($urandom % 10) == 0;
      mem_wr_grant = ($urandom % 3) != 0;
      clear = ($urandom % 200) == 0;
      start_addr = 8'($urandom);
      tick();
    end
    clear = 0;
    data_in_valid = 0;
    flush = 0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
